// File: rtl/watch_mode_ctrl.sv
// Digital-watch mode / time-set controller: display mode, edit field, counter pulses, stopwatch control.
// Optional edit auto-exit on inactivity is built when WATCH_AUTO_EXIT_EN is defined.
module watch_mode_ctrl #(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sec_tick,
  input  logic       mode_tick,
  input  logic       set_tick,
  input  logic       adv_tick,
  output logic [1:0] mode,
  output logic [1:0] field,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       clr_sec,
  output logic       alarm_en,
  output logic       sw_run,
  output logic       sw_clr,
  output logic       blink_on
);

  typedef enum logic [1:0] {NORM = 2'd0, E_HR = 2'd1, E_MIN = 2'd2, E_LAST = 2'd3} state_t;
  typedef enum logic [1:0] {M_TIME = 2'd0, M_ALARM = 2'd1, M_SW = 2'd2} mode_t;

  state_t state;
  mode_t  mode_q;
  logic   any_btn;
  logic   to_hit;

  if (TIMEOUT_S < 1 || TIMEOUT_S > 255) begin : g_bad_timeout
    $error("watch_mode_ctrl: TIMEOUT_S must be in 1..255");
  end

  assign field   = state;
  assign mode    = mode_q;
  assign any_btn = set_tick | mode_tick | adv_tick;

`ifdef WATCH_AUTO_EXIT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_S - 1);
  logic [7:0] to_cnt;

  // A button in the same cycle as the final sec_tick suppresses the timeout.
  assign to_hit = sec_tick && !any_btn && (state != NORM) && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt <= '0;
    end else if (state == NORM || any_btn || to_hit) begin
      to_cnt <= '0;
    end else if (sec_tick) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= NORM;
      mode_q   <= M_TIME;
      inc_hr   <= 1'b0;
      inc_min  <= 1'b0;
      clr_sec  <= 1'b0;
      alarm_en <= 1'b0;
      sw_run   <= 1'b0;
      sw_clr   <= 1'b0;
      blink_on <= 1'b1;
    end else begin
      inc_hr  <= 1'b0;
      inc_min <= 1'b0;
      clr_sec <= 1'b0;
      sw_clr  <= 1'b0;
      if (set_tick) begin
        blink_on <= 1'b1;
        case (state)
          NORM: begin
            if (mode_q == M_SW) sw_run <= ~sw_run;
            else                state  <= E_HR;
          end
          E_HR:    state <= E_MIN;
          E_MIN:   state <= E_LAST;
          default: state <= NORM;
        endcase
      end else if (mode_tick) begin
        blink_on <= 1'b1;
        if (state == NORM) begin
          case (mode_q)
            M_TIME:  mode_q <= M_ALARM;
            M_ALARM: mode_q <= M_SW;
            default: mode_q <= M_TIME;
          endcase
        end
      end else if (adv_tick) begin
        blink_on <= 1'b1;
        case (state)
          NORM:   if (mode_q == M_SW && !sw_run) sw_clr <= 1'b1;
          E_HR:   inc_hr  <= 1'b1;
          E_MIN:  inc_min <= 1'b1;
          E_LAST: begin
            if (mode_q == M_TIME)       clr_sec  <= 1'b1;
            else if (mode_q == M_ALARM) alarm_en <= ~alarm_en;
          end
          default: ;
        endcase
      end else if (sec_tick && state != NORM) begin
        if (to_hit) begin
          state    <= NORM;
          blink_on <= 1'b1;
        end else begin
          blink_on <= ~blink_on;
        end
      end
    end
  end

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Table-driven scoreboard bench for watch_mode_ctrl; auto-exit case follows WATCH_AUTO_EXIT_EN.
module tb_watch_mode_ctrl;

  localparam logic [3:0] N = 4'b0000, S = 4'b1000, M = 4'b0100, A = 4'b0010, T = 4'b0001;

  typedef struct packed {
    logic [3:0]  in;   // {set, mode, adv, sec}
    logic [10:0] exp;  // {mode, field, inc_hr, inc_min, clr_sec, alarm_en, sw_run, sw_clr, blink_on}
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       sec_tick, mode_tick, set_tick, adv_tick;
  logic [1:0] mode, field;
  logic       inc_hr, inc_min, clr_sec, alarm_en, sw_run, sw_clr, blink_on;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [10:0] exp_q[$];
  vec_t        tbl[$];

  watch_mode_ctrl #(.TIMEOUT_S(3)) dut (
    .clk(clk), .rstn(rstn), .sec_tick(sec_tick), .mode_tick(mode_tick),
    .set_tick(set_tick), .adv_tick(adv_tick), .mode(mode), .field(field),
    .inc_hr(inc_hr), .inc_min(inc_min), .clr_sec(clr_sec), .alarm_en(alarm_en),
    .sw_run(sw_run), .sw_clr(sw_clr), .blink_on(blink_on)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic [3:0] in, logic [1:0] md, logic [1:0] fl, logic [2:0] pul,
                             logic aen, logic run, logic swc, logic blk);
    vec_t r;
    r.in  = in;
    r.exp = {md, fl, pul, aen, run, swc, blk};
    return r;
  endfunction

  task automatic check(string nm);
    logic [10:0] e, a;
    a = {mode, field, inc_hr, inc_min, clr_sec, alarm_en, sw_run, sw_clr, blink_on};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, got %b", nm, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got %b expected %b", nm, a, e);
      end
    end
  endtask

  task automatic step(vec_t tv, string nm);
    @(negedge clk);
    {set_tick, mode_tick, adv_tick, sec_tick} = tv.in;
    exp_q.push_back(tv.exp);
    @(posedge clk);
    #1;
    {set_tick, mode_tick, adv_tick, sec_tick} = '0;
    check(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    {set_tick, mode_tick, adv_tick, sec_tick} = '0;

    // mode cycling
    tbl.push_back(v(M, 1, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(M, 2, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(M, 0, 0, 3'b000, 0, 0, 0, 1));
    // time edit walk
    tbl.push_back(v(S, 0, 1, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(A, 0, 1, 3'b100, 0, 0, 0, 1));
    tbl.push_back(v(A, 0, 1, 3'b100, 0, 0, 0, 1));
    tbl.push_back(v(S, 0, 2, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(A, 0, 2, 3'b010, 0, 0, 0, 1));
    tbl.push_back(v(S, 0, 3, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(A, 0, 3, 3'b001, 0, 0, 0, 1));
    tbl.push_back(v(S, 0, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(N, 0, 0, 3'b000, 0, 0, 0, 1));
    // alarm edit
    tbl.push_back(v(M, 1, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(S, 1, 1, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(M, 1, 1, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(S, 1, 2, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(S, 1, 3, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(A, 1, 3, 3'b000, 1, 0, 0, 1));
    tbl.push_back(v(A, 1, 3, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(S, 1, 0, 3'b000, 0, 0, 0, 1));
    // stopwatch
    tbl.push_back(v(M, 2, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(S, 2, 0, 3'b000, 0, 1, 0, 1));
    tbl.push_back(v(A, 2, 0, 3'b000, 0, 1, 0, 1));
    tbl.push_back(v(S, 2, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(A, 2, 0, 3'b000, 0, 0, 1, 1));
    tbl.push_back(v(N, 2, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(S | M, 2, 0, 3'b000, 0, 1, 0, 1));
    tbl.push_back(v(M, 0, 0, 3'b000, 0, 1, 0, 1));
    // priority set > adv in E_HR
    tbl.push_back(v(S, 0, 1, 3'b000, 0, 1, 0, 1));
    tbl.push_back(v(S | A, 0, 2, 3'b000, 0, 1, 0, 1));
    tbl.push_back(v(S, 0, 3, 3'b000, 0, 1, 0, 1));
    tbl.push_back(v(S, 0, 0, 3'b000, 0, 1, 0, 1));
    // blink behaviour while editing
    tbl.push_back(v(S, 0, 1, 3'b000, 0, 1, 0, 1));
    tbl.push_back(v(T, 0, 1, 3'b000, 0, 1, 0, 0));
    tbl.push_back(v(T, 0, 1, 3'b000, 0, 1, 0, 1));
    tbl.push_back(v(T | A, 0, 1, 3'b100, 0, 1, 0, 1));
    tbl.push_back(v(T, 0, 1, 3'b000, 0, 1, 0, 0));
    tbl.push_back(v(M, 0, 1, 3'b000, 0, 1, 0, 1));
    tbl.push_back(v(S, 0, 2, 3'b000, 0, 1, 0, 1));
    tbl.push_back(v(S, 0, 3, 3'b000, 0, 1, 0, 1));
    tbl.push_back(v(S, 0, 0, 3'b000, 0, 1, 0, 1));
    tbl.push_back(v(T, 0, 0, 3'b000, 0, 1, 0, 1));

    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(11'b00_00_000_0_0_0_1);
    check("reset_hold");
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // inactivity in E_MIN: three seconds
    step(v(S, 0, 1, 3'b000, 0, 1, 0, 1), "to_ehr");
    step(v(S, 0, 2, 3'b000, 0, 1, 0, 1), "to_emin");
    step(v(T, 0, 2, 3'b000, 0, 1, 0, 0), "to_sec1");
    step(v(T, 0, 2, 3'b000, 0, 1, 0, 1), "to_sec2");
`ifdef WATCH_AUTO_EXIT_EN
    step(v(T, 0, 0, 3'b000, 0, 1, 0, 1), "to_exit");
`else
    step(v(T, 0, 2, 3'b000, 0, 1, 0, 0), "to_stay");
    step(v(S, 0, 3, 3'b000, 0, 1, 0, 1), "to_elast");
    step(v(S, 0, 0, 3'b000, 0, 1, 0, 1), "to_norm");
`endif
    step(v(T, 0, 0, 3'b000, 0, 1, 0, 1), "to_after");

    // asynchronous reset while inc_hr pulse is high
    step(v(S, 0, 1, 3'b000, 0, 1, 0, 1), "rst_ehr");
    step(v(A, 0, 1, 3'b100, 0, 1, 0, 1), "rst_pulse");
    rstn = 1'b0;
    #1;
    exp_q.push_back(11'b00_00_000_0_0_0_1);
    check("rst_async");
    @(negedge clk);
    rstn = 1'b1;
    step(v(N, 0, 0, 3'b000, 0, 0, 0, 1), "rst_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
